color_filter_stats: RTL and testbench

COLOR_FILTER_STATS -- requirements
Module: color_filter_stats

---
 rtl/color_filter_stats_pkg.sv | 21 ++
 rtl/color_filter_stats_color_match.sv | 29 ++
 rtl/color_filter_stats.sv | 172 +++++++++++++++++
 tb/tb_color_filter_stats.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/color_filter_stats_pkg.sv
// Shared constants and types for the colour filter / frame statistics block.
package color_filter_stats_pkg;

  localparam int C_IMG_COLS    = 80;
  localparam int C_IMG_ROWS    = 60;
  localparam int C_NB_IMG_PXLS = 13;
  localparam int C_NB_COL      = 7;
  localparam int C_NB_ROW      = 6;
  localparam int C_NB_COMP     = 4;
  localparam int C_NB_RGB      = 3 * C_NB_COMP;

  localparam logic [C_NB_COL-1:0] C_COL_EMPTY = 7'h7F;
  localparam logic [C_NB_ROW-1:0] C_ROW_EMPTY = 6'h3F;

  typedef struct packed {
    logic [C_NB_COMP-1:0] r;
    logic [C_NB_COMP-1:0] g;
    logic [C_NB_COMP-1:0] b;
  } rgb444_t;

endpackage

// File: rtl/color_filter_stats_color_match.sv
// Combinational dominance test: a component matches when it beats both others by more than thresh.
module color_match
  import color_filter_stats_pkg::*;
(
  input  logic [C_NB_RGB-1:0]  pxl,
  input  logic [C_NB_COMP-1:0] thresh,
  output logic [2:0]           match
);

  rgb444_t pxl_s;

  // Widened to 5 bits so other + thresh cannot wrap.
  function automatic logic dominates(input logic [C_NB_COMP-1:0] a,
                                     input logic [C_NB_COMP-1:0] o1,
                                     input logic [C_NB_COMP-1:0] o2,
                                     input logic [C_NB_COMP-1:0] t);
    logic [C_NB_COMP:0] lim1_s;
    logic [C_NB_COMP:0] lim2_s;
    lim1_s = {1'b0, o1} + {1'b0, t};
    lim2_s = {1'b0, o2} + {1'b0, t};
    return ({1'b0, a} > lim1_s) && ({1'b0, a} > lim2_s);
  endfunction

  assign pxl_s = rgb444_t'(pxl);
  assign match = {dominates(pxl_s.r, pxl_s.g, pxl_s.b, thresh),
                  dominates(pxl_s.g, pxl_s.r, pxl_s.b, thresh),
                  dominates(pxl_s.b, pxl_s.r, pxl_s.g, thresh)};

endmodule

// File: rtl/color_filter_stats.sv
// Colour filter on the capture write stream with per-frame match count.
// Optional bounding box of selected pixels when FILTER_BBOX_EN is defined.
module color_filter_stats
  import color_filter_stats_pkg::*;
#(
  parameter int c_img_cols    = C_IMG_COLS,
  parameter int c_img_rows    = C_IMG_ROWS,
  parameter int c_nb_img_pxls = C_NB_IMG_PXLS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     in_we,
  input  logic [c_nb_img_pxls-1:0] in_addr,
  input  logic [C_NB_RGB-1:0]      in_data,
  input  logic [2:0]               filter_sel,
  input  logic [C_NB_COMP-1:0]     thresh,
  output logic                     out_we,
  output logic [c_nb_img_pxls-1:0] out_addr,
  output logic [C_NB_RGB-1:0]      out_data,
  output logic                     frame_done,
  output logic [c_nb_img_pxls-1:0] pxl_match_cnt
`ifdef FILTER_BBOX_EN
  ,
  output logic [C_NB_COL-1:0]      col_min,
  output logic [C_NB_COL-1:0]      col_max,
  output logic [C_NB_ROW-1:0]      row_min,
  output logic [C_NB_ROW-1:0]      row_max
`endif
);

  localparam logic [c_nb_img_pxls-1:0] C_PXLS_W = c_nb_img_pxls'(c_img_cols * c_img_rows);
  localparam logic [c_nb_img_pxls-1:0] C_COLS_W = c_nb_img_pxls'(c_img_cols);
  localparam logic [c_nb_img_pxls-1:0] C_ONE_W  = c_nb_img_pxls'(1);

  logic [2:0]               match_s;
  logic                     valid_s;
  logic                     sel_s;
  logic [c_nb_img_pxls-1:0] base_s;
  logic [C_NB_ROW-1:0]      row_s;

  logic                     out_we_r;
  logic [c_nb_img_pxls-1:0] out_addr_r;
  logic [C_NB_RGB-1:0]      out_data_r;
  logic                     frame_done_r;
  logic [c_nb_img_pxls-1:0] pxl_match_cnt_r;
  logic [c_nb_img_pxls-1:0] cnt_r;
  logic [c_nb_img_pxls-1:0] row_base_r;
  logic [C_NB_ROW-1:0]      row_r;
  logic                     wr_seen_r;

  color_match u_color_match (
    .pxl    (in_data),
    .thresh (thresh),
    .match  (match_s)
  );

  // Qualify the write and resolve its line; a frame_start write always lands on line 0.
  always_comb begin
    valid_s = in_we && (in_addr < C_PXLS_W);
    sel_s   = valid_s && (|(match_s & filter_sel));
    base_s  = row_base_r;
    row_s   = row_r;
    if (frame_start) begin
      base_s = '0;
      row_s  = '0;
    end else if (in_addr >= row_base_r + C_COLS_W) begin
      base_s = row_base_r + C_COLS_W;
      row_s  = row_r + 6'd1;
    end else begin
      base_s = row_base_r;
      row_s  = row_r;
    end
  end

  // Output stream, frame accumulators and the frame-boundary latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_we_r        <= 1'b0;
      out_addr_r      <= '0;
      out_data_r      <= 12'h000;
      frame_done_r    <= 1'b0;
      pxl_match_cnt_r <= '0;
      cnt_r           <= '0;
      row_base_r      <= '0;
      row_r           <= '0;
      wr_seen_r       <= 1'b0;
    end else begin
      out_we_r   <= valid_s;
      out_addr_r <= in_addr;
      out_data_r <= ((filter_sel == 3'b000) || sel_s) ? in_data : 12'h000;
      if (frame_start) begin
        frame_done_r <= wr_seen_r;
        if (wr_seen_r) begin
          pxl_match_cnt_r <= cnt_r;
        end else begin
          pxl_match_cnt_r <= pxl_match_cnt_r;
        end
        wr_seen_r  <= valid_s;
        cnt_r      <= sel_s ? C_ONE_W : '0;
        row_base_r <= '0;
        row_r      <= '0;
      end else begin
        frame_done_r <= 1'b0;
        if (valid_s) begin
          wr_seen_r  <= 1'b1;
          row_base_r <= base_s;
          row_r      <= row_s;
        end else begin
          wr_seen_r  <= wr_seen_r;
        end
        if (sel_s && (cnt_r < C_PXLS_W)) begin
          cnt_r <= cnt_r + C_ONE_W;
        end else begin
          cnt_r <= cnt_r;
        end
      end
    end
  end

  assign out_we        = out_we_r;
  assign out_addr      = out_addr_r;
  assign out_data      = out_data_r;
  assign frame_done    = frame_done_r;
  assign pxl_match_cnt = pxl_match_cnt_r;

`ifdef FILTER_BBOX_EN
  logic [C_NB_COL-1:0] col_s;
  logic [C_NB_COL-1:0] col_min_acc_r, col_max_acc_r, col_min_r, col_max_r;
  logic [C_NB_ROW-1:0] row_min_acc_r, row_max_acc_r, row_min_r, row_max_r;

  assign col_s = C_NB_COL'(in_addr - base_s);

  // Bounding-box accumulation of selected pixels, latched alongside the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_min_acc_r <= C_COL_EMPTY;
      col_max_acc_r <= '0;
      row_min_acc_r <= C_ROW_EMPTY;
      row_max_acc_r <= '0;
      col_min_r     <= C_COL_EMPTY;
      col_max_r     <= '0;
      row_min_r     <= C_ROW_EMPTY;
      row_max_r     <= '0;
    end else if (frame_start) begin
      if (wr_seen_r) begin
        col_min_r <= col_min_acc_r;
        col_max_r <= col_max_acc_r;
        row_min_r <= row_min_acc_r;
        row_max_r <= row_max_acc_r;
      end
      col_min_acc_r <= sel_s ? col_s : C_COL_EMPTY;
      col_max_acc_r <= sel_s ? col_s : '0;
      row_min_acc_r <= sel_s ? row_s : C_ROW_EMPTY;
      row_max_acc_r <= sel_s ? row_s : '0;
    end else if (sel_s) begin
      if (col_s < col_min_acc_r) col_min_acc_r <= col_s;
      if (col_s > col_max_acc_r) col_max_acc_r <= col_s;
      if (row_s < row_min_acc_r) row_min_acc_r <= row_s;
      if (row_s > row_max_acc_r) row_max_acc_r <= row_s;
    end
  end

  assign col_min = col_min_r;
  assign col_max = col_max_r;
  assign row_min = row_min_r;
  assign row_max = row_max_r;
`else
  // Without the box, the filtered stream and match count are the whole result.
`endif

endmodule

// File: tb/tb_color_filter_stats.sv
// Directed bench for color_filter_stats; bounding-box checks follow FILTER_BBOX_EN.
module tb_color_filter_stats;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        in_we = 1'b0;
  logic [12:0] in_addr = 13'd0;
  logic [11:0] in_data = 12'h000;
  logic [2:0]  filter_sel = 3'b000;
  logic [3:0]  thresh = 4'd0;
  logic        out_we;
  logic [12:0] out_addr;
  logic [11:0] out_data;
  logic        frame_done;
  logic [12:0] pxl_match_cnt;
`ifdef FILTER_BBOX_EN
  logic [6:0]  col_min, col_max;
  logic [5:0]  row_min, row_max;
`endif

  int checks = 0;
  int errors = 0;

  color_filter_stats dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .in_we         (in_we),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .filter_sel    (filter_sel),
    .thresh        (thresh),
    .out_we        (out_we),
    .out_addr      (out_addr),
    .out_data      (out_data),
    .frame_done    (frame_done),
    .pxl_match_cnt (pxl_match_cnt)
`ifdef FILTER_BBOX_EN
    ,
    .col_min       (col_min),
    .col_max       (col_max),
    .row_min       (row_min),
    .row_max       (row_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, outputs of that edge are stable on return.
  task automatic cyc(input logic fs, input logic we, input logic [12:0] a, input logic [11:0] d);
    @(negedge clk);
    frame_start = fs;
    in_we       = we;
    in_addr     = a;
    in_data     = d;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    in_we       = 1'b0;
  endtask

`ifdef FILTER_BBOX_EN
  task automatic chk_box(input string tag, input logic [6:0] cmin, input logic [6:0] cmax,
                         input logic [5:0] rmin, input logic [5:0] rmax);
    chk({tag, "_col_min"}, 13'(col_min), 13'(cmin));
    chk({tag, "_col_max"}, 13'(col_max), 13'(cmax));
    chk({tag, "_row_min"}, 13'(row_min), 13'(rmin));
    chk({tag, "_row_max"}, 13'(row_max), 13'(rmax));
  endtask
`endif

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_we", 13'(out_we), 13'd0);
    chk("rst_out_addr", out_addr, 13'd0);
    chk("rst_out_data", 13'(out_data), 13'd0);
    chk("rst_frame_done", 13'(frame_done), 13'd0);
    chk("rst_cnt", pxl_match_cnt, 13'd0);
`ifdef FILTER_BBOX_EN
    chk_box("rst", 7'h7F, 7'h00, 6'h3F, 6'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Empty frame: no frame_done
    cyc(1'b1, 1'b0, 13'd0, 12'h000);
    chk("empty_done", 13'(frame_done), 13'd0);
    chk("empty_cnt", pxl_match_cnt, 13'd0);
    cyc(1'b0, 1'b0, 13'd0, 12'h000);
    chk("empty_done2", 13'(frame_done), 13'd0);

    // Red filter, margin 2
    filter_sel = 3'b100;
    thresh     = 4'd2;
    cyc(1'b0, 1'b1, 13'd5, 12'hF31);
    chk("red_we", 13'(out_we), 13'd1);
    chk("red_addr5", out_addr, 13'd5);
    chk("red_data5", 13'(out_data), 13'hF31);
    cyc(1'b0, 1'b1, 13'd6, 12'h884);
    chk("red_addr6", out_addr, 13'd6);
    chk("red_data6", 13'(out_data), 13'h000);
    cyc(1'b0, 1'b1, 13'd7, 12'h530);
    chk("margin_equal", 13'(out_data), 13'h000);
    cyc(1'b0, 1'b1, 13'd8, 12'h630);
    chk("margin_above", 13'(out_data), 13'h630);
    filter_sel = 3'b000;
    cyc(1'b0, 1'b1, 13'd9, 12'h884);
    chk("bypass_data", 13'(out_data), 13'h884);
    cyc(1'b0, 1'b0, 13'd10, 12'h000);
    chk("idle_we", 13'(out_we), 13'd0);
    filter_sel = 3'b100;
    cyc(1'b1, 1'b0, 13'd0, 12'h000);
    chk("red_done", 13'(frame_done), 13'd1);
    chk("red_cnt", pxl_match_cnt, 13'd2);
`ifdef FILTER_BBOX_EN
    chk_box("red", 7'd5, 7'd8, 6'd0, 6'd0);
`endif
    cyc(1'b0, 1'b0, 13'd0, 12'h000);
    chk("red_done_pulse", 13'(frame_done), 13'd0);

    // Full green frame plus saturation and out-of-range writes
    filter_sel = 3'b010;
    thresh     = 4'd0;
    for (int i = 0; i < 4800; i++) cyc(1'b0, 1'b1, 13'(i), 12'h0F0);
    chk("hold_cnt", pxl_match_cnt, 13'd2);
    cyc(1'b0, 1'b1, 13'd4799, 12'h0F0);
    cyc(1'b0, 1'b1, 13'd4799, 12'h0F0);
    cyc(1'b0, 1'b1, 13'd4800, 12'h0F0);
    chk("oob_we", 13'(out_we), 13'd0);
    cyc(1'b1, 1'b0, 13'd0, 12'h000);
    chk("full_done", 13'(frame_done), 13'd1);
    chk("full_cnt", pxl_match_cnt, 13'd4800);
`ifdef FILTER_BBOX_EN
    chk_box("full", 7'd0, 7'd79, 6'd0, 6'd59);
`endif

    // Two selected pixels at 163 (row 2 col 3) and 250 (row 3 col 10)
    for (int i = 0; i < 4800; i++)
      cyc(1'b0, 1'b1, 13'(i), (i == 163 || i == 250) ? 12'h0F0 : 12'h000);
    cyc(1'b0, 1'b1, 13'd4800, 12'h0F0);
    chk("oob_we2", 13'(out_we), 13'd0);
    // Simultaneous frame_start and write: pixel belongs to the new frame
    cyc(1'b1, 1'b1, 13'd0, 12'h0F0);
    chk("two_done", 13'(frame_done), 13'd1);
    chk("two_cnt", pxl_match_cnt, 13'd2);
    chk("fs_write_we", 13'(out_we), 13'd1);
`ifdef FILTER_BBOX_EN
    chk_box("two", 7'd3, 7'd10, 6'd2, 6'd3);
`endif
    cyc(1'b1, 1'b0, 13'd0, 12'h000);
    chk("fs_write_done", 13'(frame_done), 13'd1);
    chk("fs_write_cnt", pxl_match_cnt, 13'd1);
`ifdef FILTER_BBOX_EN
    chk_box("fs_write", 7'd0, 7'd0, 6'd0, 6'd0);
`endif

    // Reset mid-frame aborts it
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 13'(i), 12'h0F0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cnt", pxl_match_cnt, 13'd0);
    chk("midrst_we", 13'(out_we), 13'd0);
`ifdef FILTER_BBOX_EN
    chk_box("midrst", 7'h7F, 7'h00, 6'h3F, 6'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 13'd0, 12'h000);
    chk("postrst_done", 13'(frame_done), 13'd0);
    chk("postrst_cnt", pxl_match_cnt, 13'd0);
    cyc(1'b0, 1'b0, 13'd0, 12'h000);
    chk("postrst_done2", 13'(frame_done), 13'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
